// File: rtl/nec_ir_rx.sv
// NEC infrared remote-control receiver: rebuilds the carrier envelope from the raw
// IrDA pulse train, times marks and spaces, and decodes data and repeat frames.
module nec_ir_rx #(
    parameter bit          RX_ACTIVE_LOW  = 1'b1,
    parameter int unsigned ENV_TIMEOUT    = 480,
    parameter int unsigned LEAD_MARK_MIN  = 96000,
    parameter int unsigned LEAD_MARK_MAX  = 120000,
    parameter int unsigned LEAD_SPACE_MIN = 48000,
    parameter int unsigned LEAD_SPACE_MAX = 60000,
    parameter int unsigned REP_SPACE_MIN  = 24000,
    parameter int unsigned REP_SPACE_MAX  = 30000,
    parameter int unsigned BIT_MARK_MIN   = 4000,
    parameter int unsigned BIT_MARK_MAX   = 9000,
    parameter int unsigned ZERO_MIN       = 4000,
    parameter int unsigned ZERO_MAX       = 9000,
    parameter int unsigned ONE_MIN        = 16000,
    parameter int unsigned ONE_MAX        = 24000,
    parameter int unsigned SPACE_TIMEOUT  = ONE_MAX + 36000,
    parameter int unsigned MARK_TIMEOUT   = 131000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic [31:0] data,
    output logic        data_valid,
    output logic        repeat_valid,
    output logic        frame_err,
    output logic        check_ok,
    output logic        busy,
    output logic        env
);

    localparam int unsigned DurW = 17;
    localparam int unsigned EnvW = $clog2(ENV_TIMEOUT + 1);

    localparam logic [DurW-1:0] DurMax       = '1;
    localparam logic [DurW-1:0] LeadMarkMin  = DurW'(LEAD_MARK_MIN);
    localparam logic [DurW-1:0] LeadMarkMax  = DurW'(LEAD_MARK_MAX);
    localparam logic [DurW-1:0] LeadSpaceMin = DurW'(LEAD_SPACE_MIN);
    localparam logic [DurW-1:0] LeadSpaceMax = DurW'(LEAD_SPACE_MAX);
    localparam logic [DurW-1:0] RepSpaceMin  = DurW'(REP_SPACE_MIN);
    localparam logic [DurW-1:0] RepSpaceMax  = DurW'(REP_SPACE_MAX);
    localparam logic [DurW-1:0] BitMarkMin   = DurW'(BIT_MARK_MIN);
    localparam logic [DurW-1:0] BitMarkMax   = DurW'(BIT_MARK_MAX);
    localparam logic [DurW-1:0] ZeroMin      = DurW'(ZERO_MIN);
    localparam logic [DurW-1:0] ZeroMax      = DurW'(ZERO_MAX);
    localparam logic [DurW-1:0] OneMin       = DurW'(ONE_MIN);
    localparam logic [DurW-1:0] OneMax       = DurW'(ONE_MAX);
    localparam logic [DurW-1:0] SpaceTo      = DurW'(SPACE_TIMEOUT);
    localparam logic [DurW-1:0] MarkTo       = DurW'(MARK_TIMEOUT);
    localparam logic [EnvW-1:0] EnvLoad      = EnvW'(ENV_TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StLeadMark,
        StLeadSpace,
        StBitMark,
        StBitSpace,
        StTail
    } state_e;

    function automatic logic in_win(input logic [DurW-1:0] d, input logic [DurW-1:0] lo,
                                    input logic [DurW-1:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    function automatic logic code_check(input logic [31:0] w);
        return (w[7:0] == ~w[15:8]) && (w[23:16] == ~w[31:24]);
    endfunction

    logic [1:0]      sync_q;
    logic            pulse;
    logic [EnvW-1:0] env_cnt_q, env_cnt_d;
    logic            env_q, env_d;
    logic            env_rise, env_fall;
    logic [DurW-1:0] dur_q, dur_d;

    state_e          state_q, state_d;
    logic [5:0]      bitcnt_q, bitcnt_d;
    logic [31:0]     shift_q, shift_d;
    logic [31:0]     data_q, data_d;
    logic            chk_q, chk_d;
    logic            dv_q, dv_d;
    logic            rv_q, rv_d;
    logic            fe_q, fe_d;
    logic            bit_val;

    // Synchroniser resets to the idle line level so no phantom pulse follows reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {2{RX_ACTIVE_LOW}};
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    assign pulse = RX_ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

    always_comb begin
        env_cnt_d = env_cnt_q;
        if (pulse) begin
            env_cnt_d = EnvLoad;
        end else if (env_cnt_q != '0) begin
            env_cnt_d = env_cnt_q - 1'b1;
        end
    end

    assign env_d    = pulse | (env_cnt_q != '0);
    assign env_rise = env_d & ~env_q;
    assign env_fall = ~env_d & env_q;

    // Length of the current envelope segment; the pre-clear value at an edge is its duration.
    always_comb begin
        dur_d = dur_q;
        if (env_rise || env_fall) begin
            dur_d = '0;
        end else if (dur_q != DurMax) begin
            dur_d = dur_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            env_cnt_q <= '0;
            env_q     <= 1'b0;
            dur_q     <= '0;
        end else begin
            env_cnt_q <= env_cnt_d;
            env_q     <= env_d;
            dur_q     <= dur_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        chk_d    = chk_q;
        dv_d     = 1'b0;
        rv_d     = 1'b0;
        fe_d     = 1'b0;
        bit_val  = in_win(dur_q, OneMin, OneMax);

        unique case (state_q)
            StIdle: begin
                if (env_rise) begin
                    state_d = StLeadMark;
                end
            end
            StLeadMark: begin
                // A bad leader mark is treated as noise, not a frame error.
                if (env_fall) begin
                    state_d = in_win(dur_q, LeadMarkMin, LeadMarkMax) ? StLeadSpace : StIdle;
                end else if (dur_q > MarkTo) begin
                    state_d = StIdle;
                end
            end
            StLeadSpace: begin
                if (env_rise) begin
                    if (in_win(dur_q, LeadSpaceMin, LeadSpaceMax)) begin
                        bitcnt_d = '0;
                        state_d  = StBitMark;
                    end else if (in_win(dur_q, RepSpaceMin, RepSpaceMax)) begin
                        rv_d    = 1'b1;
                        state_d = StTail;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = StIdle;
                    end
                end else if (dur_q > SpaceTo) begin
                    fe_d    = 1'b1;
                    state_d = StIdle;
                end
            end
            StBitMark: begin
                if (env_fall) begin
                    if (in_win(dur_q, BitMarkMin, BitMarkMax)) begin
                        state_d = StBitSpace;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = StIdle;
                    end
                end else if (dur_q > MarkTo) begin
                    fe_d    = 1'b1;
                    state_d = StIdle;
                end
            end
            StBitSpace: begin
                if (env_rise) begin
                    if (in_win(dur_q, ZeroMin, ZeroMax) || bit_val) begin
                        shift_d  = {bit_val, shift_q[31:1]};
                        bitcnt_d = bitcnt_q + 6'd1;
                        if (bitcnt_d == 6'd32) begin
                            data_d  = shift_d;
                            chk_d   = code_check(shift_d);
                            dv_d    = 1'b1;
                            state_d = StTail;
                        end else begin
                            state_d = StBitMark;
                        end
                    end else begin
                        fe_d    = 1'b1;
                        state_d = StIdle;
                    end
                end else if (dur_q > SpaceTo) begin
                    fe_d    = 1'b1;
                    state_d = StIdle;
                end
            end
            StTail: begin
                if (env_fall) begin
                    state_d = StIdle;
                end else if (dur_q > MarkTo) begin
                    fe_d    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            bitcnt_q <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            chk_q    <= 1'b0;
            dv_q     <= 1'b0;
            rv_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            chk_q    <= chk_d;
            dv_q     <= dv_d;
            rv_q     <= rv_d;
            fe_q     <= fe_d;
        end
    end

    assign data         = data_q;
    assign check_ok     = chk_q;
    assign data_valid   = dv_q;
    assign repeat_valid = rv_q;
    assign frame_err    = fe_q;
    assign busy         = (state_q != StIdle);
    assign env          = env_q;

endmodule

// File: tb/tb_nec_ir_rx.sv
// Directed bench for nec_ir_rx using a time-scaled NEC timing (one 562.5 us unit = U cycles).
module tb_nec_ir_rx;

    localparam int U = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxd;
    logic [31:0] data;
    logic        data_valid, repeat_valid, frame_err, check_ok, busy, env;

    nec_ir_rx #(
        .RX_ACTIVE_LOW (1'b1),
        .ENV_TIMEOUT   (4),
        .LEAD_MARK_MIN (280),
        .LEAD_MARK_MAX (360),
        .LEAD_SPACE_MIN(140),
        .LEAD_SPACE_MAX(180),
        .REP_SPACE_MIN (70),
        .REP_SPACE_MAX (90),
        .BIT_MARK_MIN  (12),
        .BIT_MARK_MAX  (30),
        .ZERO_MIN      (12),
        .ZERO_MAX      (30),
        .ONE_MIN       (48),
        .ONE_MAX       (72),
        .SPACE_TIMEOUT (180),
        .MARK_TIMEOUT  (400)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .data        (data),
        .data_valid  (data_valid),
        .repeat_valid(repeat_valid),
        .frame_err   (frame_err),
        .check_ok    (check_ok),
        .busy        (busy),
        .env         (env)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          dv_cnt = 0, rv_cnt = 0, fe_cnt = 0, overlap_cnt = 0, cyc = 0, fe_cyc = 0;
    logic [31:0] dv_data = '0;
    int          end_cyc;
    int          lat;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (data_valid) begin
            dv_cnt  <= dv_cnt + 1;
            dv_data <= data;
        end
        if (repeat_valid) rv_cnt <= rv_cnt + 1;
        if (frame_err) begin
            fe_cnt <= fe_cnt + 1;
            fe_cyc <= cyc;
        end
        if ((32'(data_valid) + 32'(repeat_valid) + 32'(frame_err)) > 1) begin
            overlap_cnt <= overlap_cnt + 1;
        end
    end

    // Carrier burst: one low cycle every three cycles.
    task automatic mark(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rxd = (i % 3 == 0) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic space(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rxd = 1'b1;
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rst_data", data, 32'h0);
        check_val("rst_check_ok", 32'(check_ok), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_env", 32'(env), 32'd0);
        check_val("rst_strobes", {29'd0, data_valid, repeat_valid, frame_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Bits, stop mark and trailing idle; rst_bit >= 0 pulses reset inside that bit's mark.
    task automatic send_body(input logic [31:0] code, input int rst_bit);
        for (int i = 0; i < 32; i++) begin
            if (i == rst_bit) begin
                mark(10);
                reset_pulse();
                mark(U - 10);
            end else begin
                mark(U);
            end
            space(code[i] ? 3 * U : U);
        end
        mark(U);
        space(10 * U);
    endtask

    task automatic send_frame(input logic [31:0] code, input int rst_bit);
        mark(16 * U);
        space(8 * U);
        send_body(code, rst_bit);
    endtask

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_val("reset_data", data, 32'h0);
        check_val("reset_check_ok", 32'(check_ok), 32'd0);
        check_val("reset_busy", 32'(busy), 32'd0);
        check_val("reset_env", 32'(env), 32'd0);
        check_val("reset_strobes", {29'd0, data_valid, repeat_valid, frame_err}, 32'd0);

        // Short burst: envelope follows it, leader rejected silently.
        mark(40);
        #1;
        check_val("env_in_mark", 32'(env), 32'd1);
        check_val("busy_in_mark", 32'(busy), 32'd1);
        space(100);
        #1;
        check_val("env_after_mark", 32'(env), 32'd0);
        check_val("busy_after_mark", 32'(busy), 32'd0);
        check_val("short_burst_fe", fe_cnt, 0);

        // Full data frame.
        send_frame(32'hFF00FB04, -1);
        check_val("frame1_dv_cnt", dv_cnt, 1);
        check_val("frame1_dv_data", dv_data, 32'hFF00FB04);
        check_val("frame1_data", data, 32'hFF00FB04);
        check_val("frame1_check_ok", 32'(check_ok), 32'd1);
        check_val("frame1_fe", fe_cnt, 0);
        check_val("frame1_busy", 32'(busy), 32'd0);

        // Repeat frame.
        mark(16 * U);
        space(4 * U);
        mark(U);
        space(10 * U);
        check_val("repeat_rv_cnt", rv_cnt, 1);
        check_val("repeat_dv_cnt", dv_cnt, 1);
        check_val("repeat_data", data, 32'hFF00FB04);
        check_val("repeat_fe", fe_cnt, 0);
        check_val("repeat_busy", 32'(busy), 32'd0);

        // Short leader followed by a frame body, then a good frame.
        mark(213);
        space(8 * U);
        send_body(32'hFF00FB04, -1);
        check_val("badlead_dv", dv_cnt, 1);
        check_val("badlead_rv", rv_cnt, 1);
        check_val("badlead_fe", fe_cnt, 0);
        send_frame(32'hFF00FB04, -1);
        check_val("afterbad_dv", dv_cnt, 2);
        check_val("afterbad_data", data, 32'hFF00FB04);

        // Truncated frame: carrier stops after the tenth bit mark.
        mark(16 * U);
        space(8 * U);
        for (int i = 0; i < 9; i++) begin
            mark(U);
            space(((32'h12345678 >> i) & 1) != 0 ? 3 * U : U);
        end
        mark(U);
        end_cyc = cyc;
        space(400);
        lat = fe_cyc - end_cyc;
        check_val("trunc_fe_cnt", fe_cnt, 1);
        check_val("trunc_fe_latency_ok", 32'(lat >= 170 && lat <= 230), 32'd1);
        check_val("trunc_dv", dv_cnt, 2);
        check_val("trunc_data", data, 32'hFF00FB04);
        check_val("trunc_check_ok", 32'(check_ok), 32'd1);
        check_val("trunc_busy", 32'(busy), 32'd0);

        // Corrupted payload.
        send_frame(32'hFF00FB05, -1);
        check_val("corrupt_dv", dv_cnt, 3);
        check_val("corrupt_data", data, 32'hFF00FB05);
        check_val("corrupt_check_ok", 32'(check_ok), 32'd0);
        check_val("corrupt_fe", fe_cnt, 1);

        // Reset during bit 15, then a fresh frame.
        send_frame(32'hFF00FB04, 15);
        check_val("rstmid_dv", dv_cnt, 3);
        check_val("rstmid_fe", fe_cnt, 1);
        check_val("rstmid_rv", rv_cnt, 1);
        check_val("rstmid_data", data, 32'h0);
        send_frame(32'hBF40E51A, -1);
        check_val("post_rst_dv", dv_cnt, 4);
        check_val("post_rst_data", data, 32'hBF40E51A);
        check_val("post_rst_check_ok", 32'(check_ok), 32'd1);
        check_val("strobe_overlap", overlap_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
